// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

  // Loader FSM states, in frame order followed by the two terminal states.
  typedef enum logic [2:0] {
    SYNC,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] DEF_SYNC_BYTE  = 8'hA5;
  localparam int         WORD_W         = 32;
  localparam int         BYTES_PER_WORD = WORD_W / 8;
  localparam int         LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  // The loader side: consumes bytes, drives the memory write port.
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  // The environment side: byte source plus memory / observer.
  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/loader_word_asm.sv
// Assembles little-endian bytes into a 32-bit word, one lane per accepted byte.
module loader_word_asm
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);
  logic [LANE_W-1:0] lane_reg;

  // Lane index: restarts on clear, advances (and wraps) on each loaded byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      lane_reg <= '0;
    else if (clear) lane_reg <= '0;
    else if (load)  lane_reg <= lane_reg + LANE_W'(1);
  end

  // The byte landing in the top lane completes the word.
  assign word_full = load && (lane_reg == LANE_W'(BYTES_PER_WORD - 1));

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      logic [7:0] byte_reg;

      // Each lane captures the incoming byte when the index points at it.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   byte_reg <= '0;
        else if (clear)                              byte_reg <= '0;
        else if (load && lane_reg == LANE_W'(gi))    byte_reg <= byte_in;
      end

      assign word[8*gi +: 8] = byte_reg;
    end
  endgenerate

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a framed byte stream, writes words into
// instruction memory and releases the core once the checksum matches.
module imem_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE
)
(
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.master bus,
  output logic          core_hold,
  output logic          done,
  output logic          error
);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam int unsigned       MAX_WORDS = 32'd1 << ADDR_W;

  state_t            state_reg, state_next;
  logic [15:0]       len_reg;
  logic [15:0]       idx_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        csum_reg;
  logic              fire;
  logic              asm_clear;
  logic              asm_load;
  logic              word_full;
  logic [15:0]       n_words;
  logic [WORD_W-1:0] word;

  assign bus.rx_ready = (state_reg == SYNC) || (state_reg == LEN0) || (state_reg == LEN1)
                     || (state_reg == DATA) || (state_reg == CSUM);
  assign fire      = bus.rx_valid && bus.rx_ready;
  assign n_words   = {bus.rx_data, len_reg[7:0]};
  assign asm_load  = fire && (state_reg == DATA);
  // A fresh image always starts assembling at lane 0.
  assign asm_clear = fire && (state_reg == LEN1);

  loader_word_asm u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .load      (asm_load),
    .byte_in   (bus.rx_data),
    .word      (word),
    .word_full (word_full)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= SYNC;
    else       state_reg <= state_next;
  end

  // Next-state decode from the frame position and the accepted byte.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SYNC:  if (fire && bus.rx_data == SYNC_BYTE) state_next = LEN0;
      LEN0:  if (fire) state_next = LEN1;
      LEN1:  if (fire) begin
               if (32'(n_words) > MAX_WORDS) state_next = ERR;
               else if (n_words == 16'd0)    state_next = CSUM;
               else                          state_next = DATA;
             end
      DATA:  if (word_full) state_next = WRITE;
      WRITE: state_next = (idx_reg + 16'd1 == len_reg) ? CSUM : DATA;
      CSUM:  if (fire) state_next = (bus.rx_data == csum_reg) ? DONE : ERR;
      DONE:  state_next = DONE;
      ERR:   state_next = ERR;
      default: state_next = ERR;
    endcase
  end

  // Length latch, word index, write address and running XOR checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_reg  <= '0;
      idx_reg  <= '0;
      addr_reg <= BASE;
      csum_reg <= '0;
    end else begin
      case (state_reg)
        SYNC: if (fire && bus.rx_data == SYNC_BYTE) csum_reg <= '0;
        LEN0: if (fire) begin
                len_reg[7:0] <= bus.rx_data;
                csum_reg     <= csum_reg ^ bus.rx_data;
              end
        LEN1: if (fire) begin
                len_reg[15:8] <= bus.rx_data;
                csum_reg      <= csum_reg ^ bus.rx_data;
                idx_reg       <= '0;
                addr_reg      <= BASE;
              end
        DATA: if (fire) csum_reg <= csum_reg ^ bus.rx_data;
        WRITE: begin
                idx_reg  <= idx_reg + 16'd1;
                addr_reg <= addr_reg + ADDR_W'(1);
              end
        default: ;
      endcase
    end
  end

  assign bus.mem_we    = (state_reg == WRITE);
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = word;
  assign done          = (state_reg == DONE);
  assign error         = (state_reg == ERR);
  assign core_hold     = (state_reg != DONE);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the single-cycle core's instruction memory.
- Receives a framed little-endian byte stream over a valid/ready interface, assembles 32-bit words and writes them sequentially into instruction memory.
- Holds the core in reset until the image is written and the checksum verifies.
- Replaces the bench-side hex preload for hardware bring-up; sits between the byte source (UART RX or bench driver) and the instruction memory write port.

Parameters:
- ADDR_W, 10, word-address width of instruction memory; maximum image size is 2**ADDR_W words.
- BASE_ADDR, 0, word address of the first written word.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte; transfer occurs when rx_valid && rx_ready at a rising edge.
- mem_we  output  1  one-cycle instruction memory write strobe.
- mem_addr  output  ADDR_W  word write address.
- mem_wdata  output  32  word write data.
- core_hold  output  1  high keeps the core in reset.
- done  output  1  image loaded and checksum good; sticky.
- error  output  1  frame error; sticky.

Behaviour:
- Reset values: state=SYNC, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, core_hold=1, done=0, error=0, word count=0, checksum accumulator=0.
- Reset is honoured mid-frame: everything returns to reset values and a partial image is abandoned.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count N), then N words of 4 bytes each, least-significant byte first, then CSUM.
- CSUM is the XOR of every byte after SYNC_BYTE and before CSUM.
- rx_ready is decoded from state: 1 in SYNC, LEN0, LEN1, DATA and CSUM; 0 in WRITE, DONE and ERR. No byte is consumed while rx_valid=0; gaps of any length are legal.
- SYNC: accepted bytes other than SYNC_BYTE are discarded. SYNC_BYTE clears the accumulator and moves to LEN0.
- LEN0 -> LEN1: latch the low count byte and XOR it into the accumulator.
- LEN1: latch the high byte and XOR it into the accumulator, then branch:
  - N > 2**ADDR_W -> ERR.
  - N = 0 -> CSUM.
  - Otherwise -> DATA, with the byte index set to 0.
- DATA: each accepted byte goes into lane [8*i +: 8] and is XORed into the accumulator. After the 4th byte, go to WRITE.
- WRITE lasts exactly one cycle:
  - mem_we=1, with mem_wdata equal to the assembled word and mem_addr = BASE_ADDR + word index.
  - The word write therefore lands 1 cycle after the 4th byte is accepted.
  - Then increment the word index: if it equals N go to CSUM, else go to DATA.
  - mem_addr wraps modulo 2**ADDR_W; a BASE_ADDR offset plus N may wrap.
- CSUM: if the accepted byte equals the accumulator, go to DONE, else go to ERR.
- DONE: done=1 and core_hold=0, both from the next cycle. Terminal until reset.
- ERR: error=1 and core_hold=1. Terminal until reset.
- mem_we is 0 in every state except WRITE.
- done and error are never both 1.

Decomposition:
- Package loader_pkg holds:
  - the state enum (SYNC, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR);
  - the default SYNC_BYTE constant;
  - localparams for the word width (32) and bytes per word (4).
- One natural sub-module: loader_word_asm, a 4-lane byte shifter/assembler with lane index, clear and a word_full flag. The FSM, counters and checksum stay in the top.

Test Plan:
- Nominal load: stream A5 02 00 93 00 50 00 13 01 A0 00 73 -> two writes, addr 0 data 32'h00500093 then addr 1 data 32'h00A00113. Each write lands one cycle after its 4th byte. Then done=1, core_hold=0, error=0.
- Bad checksum: same stream ending in 74 instead of 73 -> both writes occur, then error=1, core_hold=1, done=0, and rx_ready=0 thereafter.
- Garbage and empty image: bytes 00 FF 5A then A5 00 00 00 -> no writes, done=1. The leading garbage is accepted and ignored.
- Oversize: with ADDR_W=4, stream A5 11 00 -> error=1 immediately after LEN_HI is accepted; no mem_we pulse.
- Backpressure and gaps: nominal stream with random rx_valid gaps, with rx_valid held high during WRITE -> no byte is consumed in WRITE, same memory contents result, and done=1.
- Reset mid-load: assert reset after 2 data bytes, then replay the nominal stream -> outputs equal reset values during reset; the reload writes both words, with no stray write from the partial word; done=1.
